alu_seq: RTL



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_mul_seq.sv | 51 +++++
 rtl/alu_seq.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequencing ALU: width, op codes, FSM states.
// Imported by the interface, the top and the multiplier.
package alu_pkg;

  localparam int ALU_DATA_W = 18;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_INC    = 3'd3,
    OP_DEC    = 3'd4,
    OP_MUL    = 3'd5,
    OP_PASS_B = 3'd6,
    OP_CLR    = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Control-unit handshake and operand bus for alu_seq.
// master: start, op, alu_a, alu_b out; result, z_flag, busy, done in.
interface alu_seq_if #(
  parameter int DATA_W = alu_pkg::ALU_DATA_W
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] result;
  logic              z_flag;
  logic              busy;
  logic              done;

  modport master (
    output start, op, alu_a, alu_b,
    input  result, z_flag, busy, done
  );

  modport slave (
    input  start, op, alu_a, alu_b,
    output result, z_flag, busy, done
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per clock, LSB first.
// Ports: clk, rst_n (sync), load, a, b in; product (next value), last out.
module alu_mul_seq #(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] product,
  output logic              last
);
  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_prod;
  logic [CW-1:0]     r_cnt;
  logic              r_run;
  logic [DATA_W-1:0] w_add;

  assign w_add = r_mplier[0] ? r_mcand : '0;
  // product is the value after this cycle's step, so
  // the top can capture the final product on the last edge
  assign product = r_prod + w_add;
  assign last = r_run && (r_cnt == CW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (load) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_prod   <= product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (last)
        r_run <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequencing ALU: single-cycle ops plus iterative MUL, start/busy/done.
// Ports: clk, rst_n (sync, active-low), bus (alu_seq_if.slave).
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input logic    clk,
  input logic    rst_n,
  alu_seq_if.slave bus
);
  state_e            r_state;
  logic [DATA_W-1:0] r_result;
  logic              r_z;
  logic              r_busy;
  logic              r_done;

  op_e               w_op;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_product;
  logic              w_last;
  logic              w_load;

  assign w_op = op_e'(bus.op);
  assign w_load = bus.start && (r_state == ST_IDLE)
               && (w_op == OP_MUL);

  always_comb begin
    w_alu = '0;
    unique case (w_op)
      OP_PASS_A: w_alu = bus.alu_a;
      OP_ADD:    w_alu = bus.alu_a + bus.alu_b;
      OP_SUB:    w_alu = bus.alu_a - bus.alu_b;
      OP_INC:    w_alu = bus.alu_a + DATA_W'(1);
      OP_DEC:    w_alu = bus.alu_a - DATA_W'(1);
      OP_MUL:    w_alu = '0;
      OP_PASS_B: w_alu = bus.alu_b;
      OP_CLR:    w_alu = '0;
    endcase
  end

  alu_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .a       (bus.alu_a),
    .b       (bus.alu_b),
    .product (w_product),
    .last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_z      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (bus.start) begin
            if (w_op == OP_MUL) begin
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else begin
              r_result <= w_alu;
              r_z      <= (w_alu == '0);
              r_done   <= 1'b1;
            end
          end
        end
        (r_state == ST_MUL): begin
          if (w_last) begin
            r_result <= w_product;
            r_z      <= (w_product == '0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.z_flag = r_z;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
endmodule
